// File: rtl/instruction_fetch_pf_pkg.sv
// instruction_fetch_pf_pkg
//  Shared constants for the instruction fetch unit: FSM state encodings and
//  the default sequential PC increment.
package instruction_fetch_pf_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;  // no read outstanding
  localparam logic [1:0] ST_BUSY    = 2'd1;  // read outstanding, result wanted
  localparam logic [1:0] ST_DISCARD = 2'd2;  // read outstanding, result stale

  localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/instruction_fetch_pf_if.sv
// instruction_fetch_pf_if
//  Bundles the fetch unit's redirect input, instruction-memory req/ack bus and
//  decode-side valid/ready bus.
//  master : fetch unit (drives Mem_req/Mem_addr and the Instr_* outputs)
//  slave  : environment (memory, decode and branch redirect source)
interface instruction_fetch_pf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              Redirect;
  logic [ADDR_W-1:0] Redirect_Addr;
  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_ack;
  logic [DATA_W-1:0] Mem_rdata;
  logic              Instr_valid;
  logic              Instr_ready;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] Instr_PC;

  modport master (
    input  Redirect, Redirect_Addr, Mem_ack, Mem_rdata, Instr_ready,
    output Mem_req, Mem_addr, Instr_valid, Instr, Instr_PC
  );

  modport slave (
    output Redirect, Redirect_Addr, Mem_ack, Mem_rdata, Instr_ready,
    input  Mem_req, Mem_addr, Instr_valid, Instr, Instr_PC
  );
endinterface

// File: rtl/instruction_fetch_pf_fifo.sv
// instruction_fetch_pf_fifo
//  Synchronous prefetch FIFO holding {PC, instr} pairs.
//  i_clk/i_rst : clock, synchronous active-high reset
//  i_push/i_data : write an entry (caller guarantees room)
//  i_pop   : remove the head (ignored when empty)
//  i_flush : empty the FIFO; wins over push and pop
//  o_head  : head entry, read straight from the storage registers
//  o_count : number of valid entries
module instruction_fetch_pf_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_pf.sv
// instruction_fetch_pf
//  Instruction fetch unit with prefetch buffer. Owns the fetch PC, reads
//  instruction memory over req/ack, queues {PC, instr} pairs and hands them to
//  decode over valid/ready. Redirect flushes the queue and restarts fetch; a
//  read already in flight when the redirect arrives is completed and dropped.
//  Clk   : rising-edge clock
//  Reset : synchronous, active-high
//  bus   : instruction_fetch_pf_if master (Redirect, Mem_*, Instr_*)
module instruction_fetch_pf
  import instruction_fetch_pf_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PC_STEP    = PC_STEP_DEFAULT
) (
  input logic                    Clk,
  input logic                    Reset,
  instruction_fetch_pf_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]               r_state;
  logic [ADDR_W-1:0]        r_fetch_pc;
  logic                     r_mem_req;
  logic [ADDR_W-1:0]        r_mem_addr;

  logic [CNT_W-1:0]         w_count;
  logic [CNT_W-1:0]         w_count_after;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic                     w_ack;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_valid;
  logic                     w_credit_now;
  logic                     w_credit_after;
  logic [ADDR_W-1:0]        w_redir_pc;
  logic [ADDR_W-1:0]        w_next_pc;

  // An ack only means something while a request is up.
  assign w_ack      = bus.Mem_ack & r_mem_req;
  assign w_redir_pc = bus.Redirect_Addr & ~ADDR_W'(3);
  assign w_next_pc  = r_fetch_pc + ADDR_W'(PC_STEP);

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & bus.Instr_ready;
  assign w_push  = (r_state == ST_BUSY) & w_ack & ~bus.Redirect;

  // Occupancy once this cycle's push/pop land; a new read may be issued only
  // if its result is guaranteed a slot.
  assign w_count_after  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_credit_now   = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_credit_after = (w_count_after < CNT_W'(FIFO_DEPTH));

  // r_fetch_pc tracks the outstanding read's address in BUSY, and the next
  // address to issue in IDLE/DISCARD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.Redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_redir_pc;
            r_state    <= ST_BUSY;
          end else if (w_credit_now) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.Redirect) begin
            r_fetch_pc <= w_redir_pc;
            if (w_ack) r_mem_addr <= w_redir_pc;
            else       r_state    <= ST_DISCARD;
          end else if (w_ack) begin
            r_fetch_pc <= w_next_pc;
            if (w_credit_after) begin
              r_mem_addr <= w_next_pc;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (bus.Redirect) r_fetch_pc <= w_redir_pc;
          // FIFO is empty here (flushed on entry), so reissuing needs no credit check.
          if (w_ack) begin
            r_mem_addr <= bus.Redirect ? w_redir_pc : r_fetch_pc;
            r_state    <= ST_BUSY;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  instruction_fetch_pf_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.Redirect),
    .i_data  ({r_mem_addr, bus.Mem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.Mem_req     = r_mem_req;
  assign bus.Mem_addr    = r_mem_addr;
  assign bus.Instr_valid = w_valid;
  assign bus.Instr_PC    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.Instr       = w_head[DATA_W-1:0];

endmodule
